// File: rtl/run_ctrl.sv
// -----------------------------------------------------------------------------
// run_ctrl
//
// Run controller placed between the clock/reset source and the CPU under test.
// It synchronises the release of the external reset, keeps the CPU in reset
// for a fixed number of further cycles, then lets the CPU run while counting
// cycles. The run ends either when the CPU signals halt or when the cycle
// budget is used up. The end states are sticky until the next reset, so the
// bench can stop the run cleanly.
//
// Parameters
//   HOLD_CYCLES  cycles cpu_reset_n is held low after synchronised release (>=1)
//   MAX_CYCLES   run-cycle budget before timeout (>=1)
//   CNT_W        width of cycle_count; 2**CNT_W must exceed MAX_CYCLES
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset (0 = in reset)
//   halt         in   CPU halt indication, only looked at while running
//   cpu_reset_n  out  registered active-low CPU reset; async assert, sync release
//   running      out  1 while the CPU is running
//   halted       out  1 once the CPU has halted (sticky until reset)
//   timed_out    out  1 once the cycle budget is exhausted (sticky until reset)
//   done         out  halted | timed_out
//   cycle_count  out  number of clock edges taken while running
// -----------------------------------------------------------------------------
module run_ctrl #(
    parameter int HOLD_CYCLES = 4,
    parameter int MAX_CYCLES  = 10000,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             halt,
    output logic             cpu_reset_n,
    output logic             running,
    output logic             halted,
    output logic             timed_out,
    output logic             done,
    output logic [CNT_W-1:0] cycle_count
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // -------------------------------------------------------------------------
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("run_ctrl: HOLD_CYCLES must be at least 1");
    end
    if (MAX_CYCLES < 1) begin : g_bad_max
        $error("run_ctrl: MAX_CYCLES must be at least 1");
    end
    if ((CNT_W < 31) && (MAX_CYCLES >= (1 << CNT_W))) begin : g_bad_cnt_w
        $error("run_ctrl: CNT_W too narrow to hold MAX_CYCLES");
    end

    // -------------------------------------------------------------------------
    // Local constants
    // -------------------------------------------------------------------------
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HALTED  = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Reset release synchroniser
    // -------------------------------------------------------------------------
    // Both flops clear asynchronously, so reset assertion reaches the rest of
    // the block without delay; only the release is retimed onto clk. A glitch
    // shorter than a cycle still clears them and restarts the whole sequence.
    logic sync_ff1;
    logic rst_sync;

    // NOTE: sequential state uses non-blocking assignments (<=) so every flop
    // samples the pre-edge value of its inputs, independent of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_ff1 <= 1'b0;
            rst_sync <= 1'b0;
        end else begin
            sync_ff1 <= 1'b1;
            rst_sync <= sync_ff1;
        end
    end

    // -------------------------------------------------------------------------
    // Controller state and registered outputs
    // -------------------------------------------------------------------------
    state_t             state_q,       state_d;
    logic [HOLD_W-1:0]  hold_cnt_q,    hold_cnt_d;
    logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
    logic               cpu_reset_n_q, cpu_reset_n_d;
    logic               running_q,     running_d;
    logic               halted_q,      halted_d;
    logic               timed_out_q,   timed_out_d;
    logic [CNT_W-1:0]   count_inc;

    assign count_inc = cycle_count_q + CNT_ONE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_HOLD;
            hold_cnt_q    <= '0;
            cycle_count_q <= '0;
            cpu_reset_n_q <= 1'b0;
            running_q     <= 1'b0;
            halted_q      <= 1'b0;
            timed_out_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            cycle_count_q <= cycle_count_d;
            cpu_reset_n_q <= cpu_reset_n_d;
            running_q     <= running_d;
            halted_q      <= halted_d;
            timed_out_q   <= timed_out_d;
        end
    end

    // Next-state and next-output logic. Every register holds its value unless
    // a transition below changes it; HALTED and TIMEOUT therefore freeze all
    // outputs, including cycle_count, until reset.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the
        // case statement can leave one unassigned and infer a latch.
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        cycle_count_d = cycle_count_q;
        cpu_reset_n_d = cpu_reset_n_q;
        running_d     = running_q;
        halted_d      = halted_q;
        timed_out_d   = timed_out_q;

        case (state_q)
            ST_HOLD: begin
                // halt is deliberately ignored here: the CPU is still in reset.
                if (rst_sync) begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d       = ST_RUN;
                        cpu_reset_n_d = 1'b1;
                        running_d     = 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_ONE;
                    end
                end
            end

            ST_RUN: begin
                cycle_count_d = count_inc;
                // halt is checked first so it wins over budget exhaustion on
                // the same edge.
                if (halt) begin
                    state_d   = ST_HALTED;
                    halted_d  = 1'b1;
                    running_d = 1'b0;
                end else if (count_inc == CNT_MAX) begin
                    state_d     = ST_TIMEOUT;
                    timed_out_d = 1'b1;
                    running_d   = 1'b0;
                end
            end

            ST_HALTED,
            ST_TIMEOUT: begin
                // Terminal until reset; CPU stays out of reset for inspection.
            end

            default: begin
                state_d = ST_HOLD;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign cpu_reset_n = cpu_reset_n_q;
    assign running     = running_q;
    assign halted      = halted_q;
    assign timed_out   = timed_out_q;
    assign done        = halted_q | timed_out_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_run_ctrl
//
// Directed, self-checking bench for run_ctrl with HOLD_CYCLES=4 and
// MAX_CYCLES=20. Inputs change on the falling clock edge and outputs are
// sampled there too, i.e. half a cycle away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_run_ctrl;

    localparam int HOLD = 4;
    localparam int MAXC = 20;
    localparam int CW   = 32;

    logic          clk;
    logic          reset;
    logic          halt;
    logic          cpu_reset_n;
    logic          running;
    logic          halted;
    logic          timed_out;
    logic          done;
    logic [CW-1:0] cycle_count;

    int checks = 0;
    int errors = 0;

    run_ctrl #(
        .HOLD_CYCLES (HOLD),
        .MAX_CYCLES  (MAXC),
        .CNT_W       (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .halt        (halt),
        .cpu_reset_n (cpu_reset_n),
        .running     (running),
        .halted      (halted),
        .timed_out   (timed_out),
        .done        (done),
        .cycle_count (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, ending on a falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Full set of output checks in one call.
    task automatic check_all(input string tag, input logic [31:0] crn, input logic [31:0] run,
                             input logic [31:0] hlt, input logic [31:0] tmo,
                             input logic [31:0] dn, input logic [31:0] cnt);
        check({tag, ".cpu_reset_n"}, 32'(cpu_reset_n), crn);
        check({tag, ".running"},     32'(running),     run);
        check({tag, ".halted"},      32'(halted),      hlt);
        check({tag, ".timed_out"},   32'(timed_out),   tmo);
        check({tag, ".done"},        32'(done),        dn);
        check({tag, ".cycle_count"}, cycle_count,      cnt);
    endtask

    // Release reset on a falling edge; CPU reset must lift on the 6th rising
    // edge after release (2 synchroniser edges + HOLD edges), with count 0.
    task automatic release_and_check(input string tag);
        reset = 1'b1;
        step(HOLD + 1);
        check_all({tag, ".hold_end"}, 0, 0, 0, 0, 0, 0);
        step(1);
        check_all({tag, ".run_start"}, 1, 1, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b0;
        halt  = 1'b0;

        // 1: reset low for 3 cycles, then release.
        #1;
        check_all("t1.reset_async", 0, 0, 0, 0, 0, 0);
        step(3);
        check_all("t1.reset_clocked", 0, 0, 0, 0, 0, 0);
        release_and_check("t1");

        // 2: halt for one cycle on the 10th RUN edge.
        step(9);
        check_all("t2.pre_halt", 1, 1, 0, 0, 0, 9);
        halt = 1'b1;
        step(1);
        halt = 1'b0;
        check_all("t2.halted", 1, 0, 1, 0, 1, 10);
        step(20);
        check_all("t2.frozen", 1, 0, 1, 0, 1, 10);

        // 3: run out the budget with halt held low.
        reset = 1'b0;
        #1;
        check_all("t3.reset_from_halted", 0, 0, 0, 0, 0, 0);
        step(2);
        release_and_check("t3");
        step(MAXC - 1);
        check_all("t3.pre_timeout", 1, 1, 0, 0, 0, MAXC - 1);
        step(1);
        check_all("t3.timeout", 1, 0, 0, 1, 1, MAXC);
        step(10);
        check_all("t3.frozen", 1, 0, 0, 1, 1, MAXC);

        // 4: halt coincides with the last budget edge; halt wins.
        reset = 1'b0;
        step(2);
        release_and_check("t4");
        step(MAXC - 1);
        halt = 1'b1;
        step(1);
        halt = 1'b0;
        check_all("t4.halt_wins", 1, 0, 1, 0, 1, MAXC);

        // 5: reset asserted mid-RUN, between clock edges.
        reset = 1'b0;
        step(2);
        release_and_check("t5.setup");
        step(5);
        check_all("t5.running", 1, 1, 0, 0, 0, 5);
        #2;
        reset = 1'b0;
        #1;
        check_all("t5.async_reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        step(1);
        release_and_check("t5.restart");

        // Reset glitch shorter than a cycle, with no rising edge inside it.
        step(3);
        #2;
        reset = 1'b0;
        #1;
        check_all("glitch.async", 0, 0, 0, 0, 0, 0);
        #1;
        reset = 1'b1;
        @(negedge clk);             // first rising edge after release
        step(HOLD);                 // edges 2..HOLD+1
        check_all("glitch.hold_end", 0, 0, 0, 0, 0, 0);
        step(1);
        check_all("glitch.run_start", 1, 1, 0, 0, 0, 0);

        // 6: halt held high from reset through HOLD.
        halt  = 1'b1;
        reset = 1'b0;
        step(2);
        reset = 1'b1;
        step(HOLD + 1);
        check_all("t6.hold_ignores_halt", 0, 0, 0, 0, 0, 0);
        step(1);
        check_all("t6.run_start", 1, 1, 0, 0, 0, 0);
        step(1);
        check_all("t6.first_run_edge", 1, 0, 1, 0, 1, 1);
        halt = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
